// File: rtl/cgra_col_dispatch_if.sv
// rtl/cgra_col_dispatch_if.sv - request, kernel-memory and column signals of the CGRA column dispatcher
// master: synchronizer/memory/column side, slave: the dispatcher itself
interface cgra_col_dispatch_if #(
  parameter int N_COL      = 4,
  parameter int KER_ID_W   = 4,
  parameter int KMEM_WIDTH = 32,
  parameter int PC_W       = 5
);
  logic [N_COL-1:0]      acc_req;
  logic [KER_ID_W-1:0]   ker_id;
  logic                  acc_ack;
  logic                  kmem_req;
  logic [KER_ID_W-1:0]   kmem_addr;
  logic [KMEM_WIDTH-1:0] kmem_rdata;
  logic [N_COL-1:0]      col_start;
  logic [N_COL*PC_W-1:0] col_pc;
  logic [N_COL-1:0]      col_done;
  logic [N_COL-1:0]      col_stall;
  logic [N_COL-1:0]      acc_end;
  logic                  busy;
  logic                  err;

  modport master (
    output acc_req, ker_id, kmem_rdata, col_done,
    input  acc_ack, kmem_req, kmem_addr, col_start, col_pc, col_stall, acc_end, busy, err
  );

  modport slave (
    input  acc_req, ker_id, kmem_rdata, col_done,
    output acc_ack, kmem_req, kmem_addr, col_start, col_pc, col_stall, acc_end, busy, err
  );
endinterface

// File: rtl/cgra_col_dispatch.sv
// rtl/cgra_col_dispatch.sv - fetches a kernel start PC, launches the requested columns
// and reports group completion once every column of a kernel has finished
module cgra_col_dispatch #(
  parameter int N_COL      = 4,
  parameter int KER_ID_W   = 4,
  parameter int KMEM_WIDTH = 32,
  parameter int PC_W       = 5
) (
  input logic               clk_i,
  input logic               rst_ni,
  cgra_col_dispatch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, LAUNCH} state_e;

  state_e              state;
  logic [N_COL-1:0]    mask_reg;
  logic [KER_ID_W-1:0] id_reg;
  logic                abort_q;
  logic                kmem_req_q;
  logic                err_q;
  logic [N_COL-1:0]    busy_q;
  logic [N_COL-1:0]    done_q;
  logic [N_COL-1:0]    end_q;
  logic [N_COL-1:0]    group_q [N_COL];
  logic [PC_W-1:0]     pc_q    [N_COL];

  logic                launch;
  logic [N_COL-1:0]    start;
  logic [N_COL-1:0]    done_now;
  logic [N_COL-1:0]    complete;
  logic [PC_W-1:0]     start_pc;
  logic                unused_rdata;

  assign launch       = (state == LAUNCH) && !abort_q;
  assign start        = launch ? (mask_reg & ~busy_q) : '0;
  assign start_pc     = bus.kmem_rdata[PC_W-1:0];
  assign unused_rdata = ^bus.kmem_rdata[KMEM_WIDTH-1:PC_W];

  // A done pulse on an idle column is dropped here, so it can never satisfy a group
  assign done_now = done_q | (bus.col_done & busy_q);

  always_comb begin
    complete = '0;
    for (int j = 0; j < N_COL; j++) begin
      complete[j] = busy_q[j] && ((group_q[j] & ~done_now) == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      mask_reg   <= '0;
      id_reg     <= '0;
      abort_q    <= 1'b0;
      kmem_req_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= '0;
      done_q     <= '0;
      end_q      <= '0;
      for (int j = 0; j < N_COL; j++) begin
        group_q[j] <= '0;
        pc_q[j]    <= '0;
      end
    end else begin
      kmem_req_q <= 1'b0;
      end_q      <= complete;
      case (state)
        IDLE: begin
          if (|bus.acc_req) begin
            mask_reg   <= bus.acc_req;
            id_reg     <= bus.ker_id;
            abort_q    <= 1'b0;
            kmem_req_q <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          abort_q <= ~|bus.acc_req;
          state   <= LAUNCH;
        end
        LAUNCH: begin
          if (launch && |(mask_reg & busy_q)) err_q <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Started columns are never busy, so they cannot collide with a completing group
      for (int j = 0; j < N_COL; j++) begin
        if (complete[j]) begin
          busy_q[j]  <= 1'b0;
          done_q[j]  <= 1'b0;
          group_q[j] <= '0;
        end else if (start[j]) begin
          busy_q[j]  <= 1'b1;
          done_q[j]  <= 1'b0;
          group_q[j] <= mask_reg;
          pc_q[j]    <= start_pc;
        end else begin
          done_q[j]  <= done_now[j];
        end
      end
    end
  end

  assign bus.acc_ack   = launch;
  assign bus.kmem_req  = kmem_req_q;
  assign bus.kmem_addr = id_reg;
  assign bus.col_start = start;
  assign bus.col_stall = busy_q & done_q;
  assign bus.acc_end   = end_q;
  assign bus.busy      = (state != IDLE) || (|busy_q);
  assign bus.err       = err_q;

  for (genvar j = 0; j < N_COL; j++) begin : g_pc
    assign bus.col_pc[j*PC_W +: PC_W] = start[j] ? start_pc : pc_q[j];
  end

endmodule

// File: tb/tb_cgra_col_dispatch.sv
// tb/tb_cgra_col_dispatch.sv - directed and randomized checks of cgra_col_dispatch
// against a cycle-level reference model of requests, groups and completions
module tb_cgra_col_dispatch;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  cgra_col_dispatch_if bus ();

  cgra_col_dispatch dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] kmem [16];
  always @(posedge clk) bus.kmem_rdata <= bus.kmem_req ? kmem[bus.kmem_addr] : 32'hDEAD_BEEF;

  // reference model: request phase (0 idle, 1 fetch, 2 launch) and per-column bookkeeping
  int       m_phase;
  bit [3:0] m_mask, m_id, m_busy, m_done, m_end;
  bit       m_abort, m_err;
  bit [3:0] m_grp [4];
  bit [4:0] m_pc  [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_phase = 0; m_mask = 0; m_id = 0; m_busy = 0; m_done = 0; m_end = 0;
    m_abort = 0; m_err = 0;
    for (int j = 0; j < 4; j++) begin m_grp[j] = 0; m_pc[j] = 0; end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    bus.acc_req = 0; bus.ker_id = 0; bus.col_done = 0;
    #1;
    check("rst ack", bus.acc_ack, 0);
    check("rst kmem_req", bus.kmem_req, 0);
    check("rst kmem_addr", bus.kmem_addr, 0);
    check("rst start", bus.col_start, 0);
    check("rst pc", bus.col_pc, 0);
    check("rst stall", bus.col_stall, 0);
    check("rst end", bus.acc_end, 0);
    check("rst busy", bus.busy, 0);
    check("rst err", bus.err, 0);
    model_clear();
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  // one clock: compare every output at the negedge, then advance the model over the edge
  task automatic tick();
    bit [3:0]  exp_start, dn, comp;
    bit [19:0] exp_pc;
    bit [31:0] word;
    bit        launching;
    @(negedge clk);
    word      = kmem[m_id];
    launching = (m_phase == 2) && !m_abort;
    exp_start = launching ? (m_mask & ~m_busy) : 4'd0;
    for (int j = 0; j < 4; j++) exp_pc[j*5 +: 5] = exp_start[j] ? word[4:0] : m_pc[j];
    check("ack", bus.acc_ack, launching);
    check("kmem_req", bus.kmem_req, m_phase == 1);
    if (m_phase == 1) check("kmem_addr", bus.kmem_addr, m_id);
    check("start", bus.col_start, exp_start);
    check("pc", bus.col_pc, exp_pc);
    check("stall", bus.col_stall, m_busy & m_done);
    check("end", bus.acc_end, m_end);
    check("busy", bus.busy, (m_phase != 0) || (m_busy != 0));
    check("err", bus.err, m_err);

    for (int j = 0; j < 4; j++) dn[j] = m_done[j] || (bus.col_done[j] && m_busy[j]);
    for (int j = 0; j < 4; j++) begin
      comp[j] = m_busy[j];
      for (int k = 0; k < 4; k++) if (m_grp[j][k] && !dn[k]) comp[j] = 0;
    end
    if (launching && (m_mask & m_busy) != 0) m_err = 1;
    for (int j = 0; j < 4; j++) begin
      if (comp[j]) begin
        m_busy[j] = 0; m_done[j] = 0; m_grp[j] = 0;
      end else if (exp_start[j]) begin
        m_busy[j] = 1; m_done[j] = 0; m_grp[j] = m_mask; m_pc[j] = word[4:0];
      end else begin
        m_done[j] = dn[j];
      end
    end
    m_end = comp;
    case (m_phase)
      0: if (bus.acc_req != 0) begin
           m_mask = bus.acc_req; m_id = bus.ker_id; m_abort = 0; m_phase = 1;
         end
      1: begin m_abort = (bus.acc_req == 0); m_phase = 2; end
      default: m_phase = 0;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic launch_req(input logic [3:0] mask, input logic [3:0] id, input logic [3:0] exp_start);
    logic [31:0] w;
    w = kmem[id];
    bus.acc_req = mask; bus.ker_id = id;
    tick();
    tick();
    check("t2 ack", bus.acc_ack, 1);
    check("t2 start", bus.col_start, exp_start);
    for (int j = 0; j < 4; j++)
      if (exp_start[j]) check("t2 pc", bus.col_pc[j*5 +: 5], w[4:0]);
    tick();
    bus.acc_req = 0;
  endtask

  task automatic done_pulse(input logic [3:0] d);
    bus.col_done = d;
    tick();
    bus.col_done = 0;
  endtask

  initial begin
    logic [3:0] free, m;
    for (int i = 0; i < 16; i++) kmem[i] = $urandom;
    kmem[3] = 32'h0000_000A;
    bus.acc_req = 0; bus.ker_id = 0; bus.col_done = 0;
    do_reset();

    // single column
    launch_req(4'b0001, 4'd3, 4'b0001);
    check("single pc", bus.col_pc[4:0], 5'd10);
    idle_ticks(6);
    done_pulse(4'b0001);
    check("single end", bus.acc_end, 4'b0001);
    check("single stall", bus.col_stall, 4'b0000);
    idle_ticks(2);

    // multi-column group waits for its last member
    launch_req(4'b0110, 4'd5, 4'b0110);
    done_pulse(4'b0010);
    for (int i = 0; i < 4; i++) begin
      check("group stall", bus.col_stall, 4'b0010);
      check("group no end", bus.acc_end, 4'b0000);
      tick();
    end
    check("group stall last", bus.col_stall, 4'b0010);
    done_pulse(4'b0100);
    check("group end", bus.acc_end, 4'b0110);
    check("group stall clr", bus.col_stall, 4'b0000);
    idle_ticks(2);

    // two groups ending together
    launch_req(4'b0011, 4'd7, 4'b0011);
    launch_req(4'b1100, 4'd9, 4'b1100);
    done_pulse(4'b1111);
    check("two groups end", bus.acc_end, 4'b1111);
    idle_ticks(2);

    // overlap: column 0 already busy
    launch_req(4'b0001, 4'd1, 4'b0001);
    launch_req(4'b0011, 4'd2, 4'b0010);
    check("overlap err", bus.err, 1);
    done_pulse(4'b0011);
    check("overlap end", bus.acc_end, 4'b0011);
    idle_ticks(3);
    check("err sticky", bus.err, 1);

    // request withdrawn during FETCH
    bus.acc_req = 4'b0100; bus.ker_id = 4'd4;
    tick();
    bus.acc_req = 0;
    tick();
    check("abort ack", bus.acc_ack, 0);
    check("abort start", bus.col_start, 0);
    tick();
    check("abort idle", bus.busy, 0);

    // reset while columns busy and a fetch is in flight
    do_reset();
    launch_req(4'b0101, 4'd6, 4'b0101);
    bus.acc_req = 4'b0010; bus.ker_id = 4'd8;
    tick();
    check("pre-reset fetch", bus.kmem_req, 1);
    do_reset();
    bus.col_done = 4'b0101;
    tick();
    bus.col_done = 0;
    idle_ticks(2);
    check("no end after reset", bus.acc_end, 0);

    // randomized traffic with periodic resets to recover stuck groups
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 499) do_reset();
      if (m_phase == 0) bus.acc_req = 0;
      if (m_phase == 0 && $urandom_range(0, 3) == 0) begin
        free = ~m_busy;
        m = 4'($urandom_range(1, 15));
        if (free != 0 && $urandom_range(0, 3) != 0) begin
          for (int t = 0; t < 20 && (m & free) == 0; t++) m = 4'($urandom_range(1, 15));
          m = ((m & free) != 0) ? (m & free) : free;
        end
        bus.acc_req = m;
        bus.ker_id  = 4'($urandom_range(0, 15));
      end else if (m_phase == 1 && $urandom_range(0, 7) == 0) begin
        bus.acc_req = 0;
      end
      for (int j = 0; j < 4; j++)
        bus.col_done[j] = (m_busy[j] && !m_done[j] && $urandom_range(0, 5) == 0) ||
                          ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
